decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I instruction decode pipeline stage. Sits between fetch and execute, directly upstream of the register file.
- Drives the register-file read addresses one cycle ahead, so the register file's registered read data lines up with this stage's output register.
- Produces the immediate, control bundle and register indices for execute.
- Detects load-use hazards against the instruction it currently holds and inserts one bubble.

Parameters:
- XLEN, 32, datapath width for pc, instr and imm. Only 32 is supported.
- RESET_PC, 32'h0000_0000, value of o_pc after reset.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_instr  in  32  fetched instruction
- i_pc  in  32  pc of i_instr
- i_valid  in  1  fetch output valid
- o_ready  out  1  decode can accept i_instr this cycle
- i_flush  in  1  kill the held instruction and any incoming one
- o_rs1_addr  out  5  register file read address 1
- o_rs2_addr  out  5  register file read address 2
- o_valid  out  1  decoded instruction valid toward execute
- i_ex_ready  in  1  execute accepts this cycle
- o_pc  out  32  pc of the decoded instruction
- o_rs1  out  5  rs1 index, for forwarding
- o_rs2  out  5  rs2 index, for forwarding
- o_rd  out  5  destination index
- o_imm  out  32  sign-extended immediate
- o_alu_op  out  4  ALU operation code (package enum)
- o_use_imm  out  1  ALU operand B is the immediate
- o_use_pc  out  1  ALU operand A is the pc (AUIPC, JAL)
- o_reg_write  out  1  result is written to rd
- o_mem_read  out  1  load
- o_mem_write  out  1  store
- o_mem_funct3  out  3  load/store size and sign
- o_branch  out  1  conditional branch
- o_jump  out  1  JAL or JALR
- o_illegal  out  1  unsupported opcode, or ECALL/EBREAK

Behaviour:
- Reset: synchronous, active-high; clock i_clk. On reset: o_valid=0, o_pc=RESET_PC, every other output register=0, which is a NOP.
- Hazard: hz = o_valid & o_mem_read & (o_rd!=0) & ((uses_rs1(i_instr) & rs1==o_rd) | (uses_rs2(i_instr) & rs2==o_rd)).
- Ready: o_ready = !i_flush & !hz & (!o_valid | i_ex_ready). This is combinational.
- Accept: accept = i_valid & o_ready. On accept the output register loads the decoded i_instr with o_valid=1. The latency from accept to o_valid is 1 cycle.
- Drain without accept: i_ex_ready & !accept (including hz) sets o_valid=0, a bubble. The other output fields may hold.
- Stall: !i_ex_ready & o_valid holds every output unchanged.
- Flush: i_flush makes o_valid=0 next cycle and captures nothing. Flush has priority over accept and stall.
- RF read addresses: o_rs1_addr/o_rs2_addr = accept ? i_instr[19:15]/[24:20] : o_rs1/o_rs2. This is combinational.
  - Holding an instruction therefore re-reads the same registers every cycle, so a writeback during the stall is picked up.
- Operand-use rules:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - For an unused operand, o_rs1/o_rs2 = 0.
- rd rules: o_rd = 0 and o_reg_write = 0 for BRANCH, STORE, FENCE, SYSTEM and illegal instructions.
- Immediate formats: I, S, B, U, J. Each is sign-extended from instr[31]. The U-type immediate is instr[31:12]<<12. R-type gives imm=0.
- ALU op: taken from funct3 plus funct7[5]. funct7[5] applies only to OP and to OP-IMM shifts (SRAI).
  - OP-IMM SLLI/SRLI/SRAI with funct7 other than 0000000 or 0100000 is illegal.
- Branch and jump ops: BRANCH uses the compare op selected by funct3. JAL/JALR use ADD with o_use_imm=1.
- FENCE decodes as a NOP with o_valid=1.
- Illegal: unknown opcode, or instr[1:0]!=2'b11, sets o_illegal=1 with all side-effect controls (reg_write, mem_read, mem_write, branch, jump) = 0.
- Reset during any stall or hazard returns the stage to the reset state in the next cycle. The register file is reset in the same cycle.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams (OPC_LUI ... OPC_SYSTEM)
  - ALU op enum (ALU_ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU)
  - imm-format enum
- One combinational sub-module, imm_gen (instr, fmt -> imm). The rest is decode logic plus the output register in decode_stage.

Test Plan:
- ADDI: i_instr=0xFFB10093 (addi x1,x2,-5), i_valid=1, i_ex_ready=1.
  - Same cycle: o_rs1_addr=2.
  - Next cycle: o_valid=1, o_rd=1, o_rs1=2, o_imm=0xFFFFFFFB, o_use_imm=1, o_reg_write=1, o_alu_op=ALU_ADD.
- Load-use: 0x00802283 (lw x5,8(x0)) then 0x00528333 (add x6,x5,x5).
  - Required sequence: o_ready=0 for one cycle, then a bubble (o_valid=0), then add with o_rs1=o_rs2=5.
  - With rd=x0 instead, no bubble.
- Branch immediate: 0xFE208EE3 (beq x1,x2,-4) -> o_imm=0xFFFFFFFC, o_branch=1, o_reg_write=0, o_rd=0, o_alu_op=ALU_BEQ.
- Stall: i_ex_ready=0 for 3 cycles with addi held.
  - All outputs constant, o_ready=0, o_rs1_addr held at 2.
  - Release -> next instruction accepted.
- Flush: i_flush=1 while o_valid=1 and i_valid=1 -> o_ready=0, next cycle o_valid=0.
- Illegal: i_instr=0x00000000 -> o_illegal=1 with all side-effect controls 0.
- Reset: assert i_reset mid-hazard -> o_valid=0, o_pc=RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate formats
// and operand-use helpers.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_BEQ  = 4'd10, ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12, ALU_BGE  = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5
    } imm_fmt_e;

    function automatic logic uses_rs1(input logic [31:0] instr);
        case (instr[6:0])
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: uses_rs1 = 1'b1;
            default: uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] instr);
        case (instr[6:0])
            OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles and sign-extends the RV32I immediate for the selected format.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Format-selected immediate assembly; R-type and unknown formats yield zero.
    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the fetched instruction into an output register for execute,
// drives register-file read addresses a cycle early and inserts one bubble on load-use.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic            o_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output logic [3:0]      o_alu_op,
    output logic            o_use_imm,
    output logic            o_use_pc,
    output logic            o_reg_write,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic [2:0]      o_mem_funct3,
    output logic            o_branch,
    output logic            o_jump,
    output logic            o_illegal
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    imm_fmt_e    fmt_s;
    alu_op_e     alu_s;
    logic        use_imm_s, use_pc_s, reg_write_s, mem_read_s, mem_write_s, branch_s, jump_s;
    logic        illegal_op_s, illegal_s;
    logic [2:0]  mem_f3_s;
    logic [31:0] imm_s;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic        hz_s, accept_s;

    assign opcode_s = i_instr[6:0];
    assign funct3_s = i_instr[14:12];
    assign funct7_s = i_instr[31:25];

    imm_gen u_imm_gen (
        .instr (i_instr[31:7]),
        .fmt   (fmt_s),
        .imm   (imm_s)
    );

    // Opcode/funct decode into raw control signals before illegal masking.
    always_comb begin
        fmt_s        = IMM_R;
        alu_s        = ALU_ADD;
        use_imm_s    = 1'b0;
        use_pc_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_f3_s     = 3'd0;
        branch_s     = 1'b0;
        jump_s       = 1'b0;
        illegal_op_s = 1'b0;
        case (opcode_s)
            OPC_LUI:    begin fmt_s = IMM_U; use_imm_s = 1'b1; reg_write_s = 1'b1; end
            OPC_AUIPC:  begin fmt_s = IMM_U; use_imm_s = 1'b1; use_pc_s = 1'b1; reg_write_s = 1'b1; end
            OPC_JAL:    begin fmt_s = IMM_J; use_imm_s = 1'b1; use_pc_s = 1'b1; reg_write_s = 1'b1; jump_s = 1'b1; end
            OPC_JALR:   begin fmt_s = IMM_I; use_imm_s = 1'b1; reg_write_s = 1'b1; jump_s = 1'b1; end
            OPC_BRANCH: begin
                fmt_s    = IMM_B;
                branch_s = 1'b1;
                case (funct3_s)
                    3'b000:  alu_s = ALU_BEQ;
                    3'b001:  alu_s = ALU_BNE;
                    3'b100:  alu_s = ALU_BLT;
                    3'b101:  alu_s = ALU_BGE;
                    3'b110:  alu_s = ALU_BLTU;
                    3'b111:  alu_s = ALU_BGEU;
                    default: alu_s = ALU_BEQ;
                endcase
            end
            OPC_LOAD:   begin fmt_s = IMM_I; use_imm_s = 1'b1; reg_write_s = 1'b1; mem_read_s = 1'b1; mem_f3_s = funct3_s; end
            OPC_STORE:  begin fmt_s = IMM_S; use_imm_s = 1'b1; mem_write_s = 1'b1; mem_f3_s = funct3_s; end
            OPC_OP_IMM: begin
                fmt_s       = IMM_I;
                use_imm_s   = 1'b1;
                reg_write_s = 1'b1;
                case (funct3_s)
                    3'b000:  alu_s = ALU_ADD;
                    3'b010:  alu_s = ALU_SLT;
                    3'b011:  alu_s = ALU_SLTU;
                    3'b100:  alu_s = ALU_XOR;
                    3'b110:  alu_s = ALU_OR;
                    3'b111:  alu_s = ALU_AND;
                    3'b001:  begin
                        if (funct7_s == 7'b0000000) alu_s = ALU_SLL;
                        else                        illegal_op_s = 1'b1;
                    end
                    3'b101:  begin
                        if (funct7_s == 7'b0000000)      alu_s = ALU_SRL;
                        else if (funct7_s == 7'b0100000) alu_s = ALU_SRA;
                        else                             illegal_op_s = 1'b1;
                    end
                    default: alu_s = ALU_ADD;
                endcase
            end
            OPC_OP:     begin
                reg_write_s = 1'b1;
                case (funct3_s)
                    3'b000:  alu_s = funct7_s[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_s = ALU_SLL;
                    3'b010:  alu_s = ALU_SLT;
                    3'b011:  alu_s = ALU_SLTU;
                    3'b100:  alu_s = ALU_XOR;
                    3'b101:  alu_s = funct7_s[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_s = ALU_OR;
                    3'b111:  alu_s = ALU_AND;
                    default: alu_s = ALU_ADD;
                endcase
            end
            OPC_FENCE:  fmt_s = IMM_R;
            OPC_SYSTEM: illegal_op_s = 1'b1;
            default:    illegal_op_s = 1'b1;
        endcase
    end

    // Illegal encodings lose every side effect, and rd is only reported when it is written.
    assign illegal_s = illegal_op_s | (i_instr[1:0] != 2'b11);
    assign rd_s      = (reg_write_s & ~illegal_s) ? i_instr[11:7] : 5'd0;
    assign rs1_s     = uses_rs1(i_instr) ? i_instr[19:15] : 5'd0;
    assign rs2_s     = uses_rs2(i_instr) ? i_instr[24:20] : 5'd0;

    assign hz_s = o_valid & o_mem_read & (o_rd != 5'd0) &
                  ((uses_rs1(i_instr) & (i_instr[19:15] == o_rd)) |
                   (uses_rs2(i_instr) & (i_instr[24:20] == o_rd)));

    assign o_ready    = ~i_flush & ~hz_s & (~o_valid | i_ex_ready);
    assign accept_s   = i_valid & o_ready;
    assign o_rs1_addr = accept_s ? i_instr[19:15] : o_rs1;
    assign o_rs2_addr = accept_s ? i_instr[24:20] : o_rs2;

    // Output register: reset, flush, accept, drain to bubble, or hold while execute stalls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_pc         <= RESET_PC;
            o_rs1        <= 5'd0;
            o_rs2        <= 5'd0;
            o_rd         <= 5'd0;
            o_imm        <= 32'd0;
            o_alu_op     <= 4'd0;
            o_use_imm    <= 1'b0;
            o_use_pc     <= 1'b0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_funct3 <= 3'd0;
            o_branch     <= 1'b0;
            o_jump       <= 1'b0;
            o_illegal    <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (accept_s) begin
            o_valid      <= 1'b1;
            o_pc         <= i_pc;
            o_rs1        <= rs1_s;
            o_rs2        <= rs2_s;
            o_rd         <= rd_s;
            o_imm        <= imm_s;
            o_alu_op     <= alu_s;
            o_use_imm    <= use_imm_s;
            o_use_pc     <= use_pc_s;
            o_reg_write  <= reg_write_s & ~illegal_s;
            o_mem_read   <= mem_read_s & ~illegal_s;
            o_mem_write  <= mem_write_s & ~illegal_s;
            o_mem_funct3 <= mem_f3_s;
            o_branch     <= branch_s & ~illegal_s;
            o_jump       <= jump_s & ~illegal_s;
            o_illegal    <= illegal_s;
        end else if (i_ex_ready) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus load-use, stall, flush and reset sequences.
module tb_decode_stage;
    import rv32_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0400;

    logic        i_clk, i_reset, i_valid, i_flush, i_ex_ready;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid, o_use_imm, o_use_pc, o_reg_write, o_mem_read, o_mem_write;
    logic        o_branch, o_jump, o_illegal;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rs1, o_rs2, o_rd;
    logic [31:0] o_pc, o_imm;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_mem_funct3;

    decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr), .i_pc(i_pc), .i_valid(i_valid),
        .o_ready(o_ready), .i_flush(i_flush), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .o_valid(o_valid), .i_ex_ready(i_ex_ready), .o_pc(o_pc), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_rd(o_rd), .o_imm(o_imm), .o_alu_op(o_alu_op), .o_use_imm(o_use_imm), .o_use_pc(o_use_pc),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_funct3(o_mem_funct3), .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // ctl = {use_imm, use_pc, reg_write, mem_read, mem_write, branch, jump, illegal}
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [7:0]  ctl;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input logic [3:0] alu,
                                input logic [2:0] f3, input logic [7:0] ctl);
        vec_t v;
        v.instr = ins; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = imm; v.alu = alu; v.f3 = f3; v.ctl = ctl;
        return v;
    endfunction

    initial begin
        logic [31:0] ins;
        logic [7:0]  ctl_now;

        tbl[0]  = mk(32'hFFB10093, 5'd1,  5'd2,  5'd0,  32'hFFFFFFFB, ALU_ADD,  3'd0, 8'b1010_0000); // addi x1,x2,-5
        tbl[1]  = mk(32'hFE208EE3, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, ALU_BEQ,  3'd0, 8'b0000_0100); // beq x1,x2,-4
        tbl[2]  = mk(32'h123451B7, 5'd3,  5'd0,  5'd0,  32'h12345000, ALU_ADD,  3'd0, 8'b1010_0000); // lui
        tbl[3]  = mk(32'hFFFFF217, 5'd4,  5'd0,  5'd0,  32'hFFFFF000, ALU_ADD,  3'd0, 8'b1110_0000); // auipc
        tbl[4]  = mk(32'h008000EF, 5'd1,  5'd0,  5'd0,  32'h00000008, ALU_ADD,  3'd0, 8'b1110_0010); // jal x1,+8
        tbl[5]  = mk(32'h00008067, 5'd0,  5'd1,  5'd0,  32'h00000000, ALU_ADD,  3'd0, 8'b1010_0010); // jalr x0,0(x1)
        tbl[6]  = mk(32'h00512623, 5'd0,  5'd2,  5'd5,  32'h0000000C, ALU_ADD,  3'd2, 8'b1000_1000); // sw x5,12(x2)
        tbl[7]  = mk(32'hFFF18383, 5'd7,  5'd3,  5'd0,  32'hFFFFFFFF, ALU_ADD,  3'd0, 8'b1011_0000); // lb x7,-1(x3)
        tbl[8]  = mk(32'h40A48433, 5'd8,  5'd9,  5'd10, 32'h00000000, ALU_SUB,  3'd0, 8'b0010_0000); // sub x8,x9,x10
        tbl[9]  = mk(32'h40365593, 5'd11, 5'd12, 5'd0,  32'h00000403, ALU_SRA,  3'd0, 8'b1010_0000); // srai x11,x12,3
        tbl[10] = mk(32'h0F037293, 5'd5,  5'd6,  5'd0,  32'h000000F0, ALU_AND,  3'd0, 8'b1010_0000); // andi x5,x6,0xf0
        tbl[11] = mk(32'h0FF0000F, 5'd0,  5'd0,  5'd0,  32'h00000000, ALU_ADD,  3'd0, 8'b0000_0000); // fence
        tbl[12] = mk(32'h00000000, 5'd0,  5'd0,  5'd0,  32'h00000000, ALU_ADD,  3'd0, 8'b0000_0001); // all-zero word
        tbl[13] = mk(32'h00000073, 5'd0,  5'd0,  5'd0,  32'h00000000, ALU_ADD,  3'd0, 8'b0000_0001); // ecall

        i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b1;
        i_instr = 32'h0; i_pc = 32'h0;
        tick(); tick();
        i_reset = 1'b0;
        #1;
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_pc", o_pc, RPC);
        chk("reset_rd", {27'd0, o_rd}, 32'd0);
        chk("reset_imm", o_imm, 32'd0);
        ctl_now = {o_use_imm, o_use_pc, o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal};
        chk("reset_ctl", {24'd0, ctl_now}, 32'd0);
        chk("reset_ready", {31'd0, o_ready}, 32'd1);

        for (int i = 0; i < 14; i++) begin
            ins = tbl[i].instr;
            i_instr = ins; i_pc = 32'h100 + 32'(4 * i); i_valid = 1'b1;
            #1;
            chk("tbl_ready", {31'd0, o_ready}, 32'd1);
            chk("tbl_rs1_addr", {27'd0, o_rs1_addr}, {27'd0, ins[19:15]});
            chk("tbl_rs2_addr", {27'd0, o_rs2_addr}, {27'd0, ins[24:20]});
            tick();
            ctl_now = {o_use_imm, o_use_pc, o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal};
            chk("tbl_valid", {31'd0, o_valid}, 32'd1);
            chk("tbl_pc", o_pc, 32'h100 + 32'(4 * i));
            chk("tbl_rd", {27'd0, o_rd}, {27'd0, tbl[i].rd});
            chk("tbl_rs1", {27'd0, o_rs1}, {27'd0, tbl[i].rs1});
            chk("tbl_rs2", {27'd0, o_rs2}, {27'd0, tbl[i].rs2});
            chk("tbl_imm", o_imm, tbl[i].imm);
            chk("tbl_alu", {28'd0, o_alu_op}, {28'd0, tbl[i].alu});
            chk("tbl_f3", {29'd0, o_mem_funct3}, {29'd0, tbl[i].f3});
            chk("tbl_ctl", {24'd0, ctl_now}, {24'd0, tbl[i].ctl});
        end

        // load-use: lw x5 then add x6,x5,x5 -> not ready, bubble, then add
        i_instr = 32'h00802283; i_pc = 32'h200;
        tick();
        chk("lu_load_rd", {27'd0, o_rd}, 32'd5);
        i_instr = 32'h00528333; i_pc = 32'h204;
        #1;
        chk("lu_ready_low", {31'd0, o_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'd0, o_valid}, 32'd0);
        chk("lu_ready_back", {31'd0, o_ready}, 32'd1);
        tick();
        chk("lu_add_valid", {31'd0, o_valid}, 32'd1);
        chk("lu_add_rs1", {27'd0, o_rs1}, 32'd5);
        chk("lu_add_rs2", {27'd0, o_rs2}, 32'd5);
        chk("lu_add_pc", o_pc, 32'h204);

        // load to x0 never stalls a reader of x0
        i_instr = 32'h00802003; i_pc = 32'h208;
        tick();
        i_instr = 32'h00000333; i_pc = 32'h20C;
        #1;
        chk("lu_x0_ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk("lu_x0_valid", {31'd0, o_valid}, 32'd1);
        chk("lu_x0_pc", o_pc, 32'h20C);

        // stall: addi held for 3 cycles while execute is busy
        i_instr = 32'hFFB10093; i_pc = 32'h300;
        tick();
        i_ex_ready = 1'b0; i_instr = 32'h00528333; i_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_ready", {31'd0, o_ready}, 32'd0);
            chk("st_rs1_addr", {27'd0, o_rs1_addr}, 32'd2);
            chk("st_valid", {31'd0, o_valid}, 32'd1);
            chk("st_pc", o_pc, 32'h300);
            chk("st_imm", o_imm, 32'hFFFFFFFB);
            chk("st_rd", {27'd0, o_rd}, 32'd1);
            tick();
        end
        i_ex_ready = 1'b1;
        #1;
        chk("st_release_ready", {31'd0, o_ready}, 32'd1);
        tick();
        chk("st_next_pc", o_pc, 32'h304);
        chk("st_next_rd", {27'd0, o_rd}, 32'd6);

        // flush while holding a valid instruction with another incoming
        i_flush = 1'b1; i_instr = 32'hFFB10093; i_pc = 32'h308;
        #1;
        chk("fl_ready", {31'd0, o_ready}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, o_valid}, 32'd0);
        chk("fl_pc_kept", o_pc, 32'h304);
        i_flush = 1'b0;

        // reset in the middle of a load-use hazard
        i_instr = 32'h00802283; i_pc = 32'h400;
        tick();
        i_instr = 32'h00528333; i_pc = 32'h404;
        #1;
        chk("rh_ready", {31'd0, o_ready}, 32'd0);
        i_reset = 1'b1;
        tick();
        chk("rh_valid", {31'd0, o_valid}, 32'd0);
        chk("rh_pc", o_pc, RPC);
        chk("rh_rd", {27'd0, o_rd}, 32'd0);
        chk("rh_mem_read", {31'd0, o_mem_read}, 32'd0);
        i_reset = 1'b0; i_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
